dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter sharing the single-port synchronous data RAM between the pipeline MEM stage (core port) and a debug/program-loader port (dbg port). It decides grants every cycle, muxes the winner's request onto the RAM and routes the RAM's one-cycle-latency read data back to the owner. It raises a stall toward the core whenever the core loses arbitration. A bounded-wait counter and a bounded lock window guarantee forward progress for both requesters.

## Interface
Parameters:
- AW, 8, RAM word-address width
- DW, 32, data width
- MAX_WAIT, 3, consecutive denied cycles after which dbg is forced ahead of core (≥1)
- LOCK_MAX, 8, maximum cycles dbg may hold an exclusive lock (≥1)

Ports:
- clock  in  1  single clock; all state changes on rising edge
- clear  in  1  asynchronous active-low reset
- core_req / core_we  in  1 / 1  core access request / write (1) vs read (0)
- core_addr / core_wdata / core_func3  in  AW / DW / 3  core request payload
- core_gnt  out  1  core request accepted this cycle
- core_stall  out  1  core_req & ~core_gnt
- core_rvalid / core_rdata  out  1 / DW  core read-data return
- dbg_req / dbg_we / dbg_lock  in  1 / 1 / 1  dbg request, write, exclusive-lock request
- dbg_addr / dbg_wdata / dbg_func3  in  AW / DW / 3  dbg request payload
- dbg_gnt  out  1  dbg request accepted this cycle
- dbg_rvalid / dbg_rdata  out  1 / DW  dbg read-data return
- mem_addr / mem_din / mem_func3  out  AW / DW / 3  to RAM
- mem_wren  out  1  RAM write enable
- mem_dout  in  DW  RAM read data, valid one cycle after the address

## Operation
- Requesters hold req and payload stable until gnt; a grant is a single-cycle accept of one access.
- States: S_CORE (reset state), S_LOCK, S_RELEASE. The state register and wait_cnt decide the grants; the grants are combinational from these and the req inputs.
- S_CORE:
  - If wait_cnt==MAX_WAIT and dbg_req: dbg_gnt=1, core_gnt=0.
  - Else if core_req: core_gnt=1.
  - Else if dbg_req: dbg_gnt=1.
  - Next state is S_LOCK if dbg_gnt & dbg_lock; otherwise stay in S_CORE.
- S_LOCK:
  - core_gnt=0; dbg_gnt=dbg_req; lock_cnt increments each cycle.
  - Next state is S_RELEASE if ~dbg_lock or lock_cnt==LOCK_MAX-1.
- S_RELEASE:
  - dbg_gnt=0; core_gnt=core_req.
  - Always returns to S_CORE. This guarantees the core at least one slot after every lock.
- wait_cnt (saturating at MAX_WAIT):
  - Increments when dbg_req & ~dbg_gnt.
  - Clears when dbg_gnt or ~dbg_req.
- lock_cnt clears on every entry to S_LOCK and in every other state.
- RAM mux: the winner's addr/wdata/func3 drive mem_*, and mem_wren = winner's we.
  - With no grant, mem_addr=0, mem_din=0, mem_func3=0 and mem_wren=0.
- Read return:
  - A granted read (we=0) registers rd_pending=1 and owner.
  - The next cycle, the owner's rvalid=1 and its rdata=mem_dout.
  - The non-owner's rdata holds 0.
  - Writes produce no rvalid.

## Timing
- Reset (clear=0, asynchronous) forces:
  - state=S_CORE, wait_cnt=0, lock_cnt=0, rd_pending=0.
  - All gnt/rvalid outputs 0, all rdata 0, mem_wren 0.
- Grant latency is 0 cycles; read-data latency is exactly 1 cycle after the grant cycle. Back-to-back reads return on consecutive cycles.
- Worst-case dbg wait with core always requesting is MAX_WAIT cycles outside a lock.
- Worst-case core wait is LOCK_MAX+1 cycles: the lock window plus the S_RELEASE cycle, counted from lock entry.
- Simultaneous requests in S_CORE with wait_cnt<MAX_WAIT: the core wins.
- If dbg drops dbg_req while in S_LOCK with dbg_lock=1, the lock is held and the RAM stays idle.
- If clear asserts mid-lock or with a read pending, the in-flight rvalid is suppressed and the lock is released.

## Test plan
- Reset, core-only traffic:
  - Stimulus: core write addr 0x10 data 0xDEADBEEF, then core read 0x10.
  - Required: core_gnt=1 both cycles, mem_wren=1 on the first.
  - Required: core_rvalid=1 with core_rdata=0xDEADBEEF one cycle after the read grant; core_stall=0 throughout.
- Contention (MAX_WAIT=3):
  - Stimulus: core_req and dbg_req held high continuously.
  - Required: core granted cycles 0-2 and dbg granted cycle 3; wait_cnt returns to 0 and the pattern repeats every 4 cycles.
  - Required: core_stall=1 exactly on the dbg-grant cycles.
- Lock window (LOCK_MAX=8):
  - Stimulus: dbg_lock=1 and dbg_req=1 held high while the core requests.
  - Required: dbg granted on the entry cycle plus 8 cycles in S_LOCK, then one S_RELEASE cycle with core_gnt=1.
  - Required: dbg is not granted in S_RELEASE.
- Early unlock:
  - Stimulus: dbg locks, performs 2 writes, then drops dbg_lock.
  - Required: S_RELEASE follows the next edge, and the core is granted within 1 cycle.
- Read routing:
  - Stimulus: dbg read 0x20 (RAM holds 0x12345678) immediately followed by a core read 0x21 (holds 0xCAFEF00D).
  - Required: dbg_rvalid then core_rvalid on consecutive cycles with the correct data; the other port's rvalid stays 0.
- Asynchronous reset:
  - Stimulus: assert clear mid-lock with a read pending.
  - Required: immediately all gnt/rvalid/mem_wren=0; after release, state is S_CORE and the first core_req is granted the same cycle.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bundle of the core, debug and RAM-side signals around the data-memory arbiter.
// The slave modport is the arbiter's view; master is the requester/RAM side.
interface dmem_arbiter_if #(
   parameter int unsigned AW = 8,
   parameter int unsigned DW = 32
);
   logic          core_req;
   logic          core_we;
   logic [AW-1:0] core_addr;
   logic [DW-1:0] core_wdata;
   logic [2:0]    core_func3;
   logic          core_gnt;
   logic          core_stall;
   logic          core_rvalid;
   logic [DW-1:0] core_rdata;

   logic          dbg_req;
   logic          dbg_we;
   logic          dbg_lock;
   logic [AW-1:0] dbg_addr;
   logic [DW-1:0] dbg_wdata;
   logic [2:0]    dbg_func3;
   logic          dbg_gnt;
   logic          dbg_rvalid;
   logic [DW-1:0] dbg_rdata;

   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_din;
   logic [2:0]    mem_func3;
   logic          mem_wren;
   logic [DW-1:0] mem_dout;

   modport slave (
      input  core_req, core_we, core_addr, core_wdata, core_func3,
      output core_gnt, core_stall, core_rvalid, core_rdata,
      input  dbg_req, dbg_we, dbg_lock, dbg_addr, dbg_wdata, dbg_func3,
      output dbg_gnt, dbg_rvalid, dbg_rdata,
      output mem_addr, mem_din, mem_func3, mem_wren,
      input  mem_dout
   );

   modport master (
      output core_req, core_we, core_addr, core_wdata, core_func3,
      input  core_gnt, core_stall, core_rvalid, core_rdata,
      output dbg_req, dbg_we, dbg_lock, dbg_addr, dbg_wdata, dbg_func3,
      input  dbg_gnt, dbg_rvalid, dbg_rdata,
      input  mem_addr, mem_din, mem_func3, mem_wren,
      output mem_dout
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares the single-port data RAM between the core MEM stage and the debug port,
// with bounded debug wait and a bounded exclusive debug lock window.
module dmem_arbiter #(
   parameter int unsigned AW       = 8,
   parameter int unsigned DW       = 32,
   parameter int unsigned MAX_WAIT = 3,
   parameter int unsigned LOCK_MAX = 8
) (
   input logic            clock,
   input logic            clear,
   dmem_arbiter_if.slave  bus
);
   localparam int unsigned WW = $clog2(MAX_WAIT + 1);
   localparam int unsigned LW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;

   typedef enum logic [1:0] {StCore, StLock, StRelease} stateT;

   stateT         state;
   logic [WW-1:0] waitCnt;
   logic [LW-1:0] lockCnt;
   logic          rdPending;
   logic          rdOwnerDbg;
   logic          coreGnt;
   logic          dbgGnt;

   always_comb begin
      coreGnt = 1'b0;
      dbgGnt  = 1'b0;
      unique case (state)
         StCore: begin
            if (waitCnt == WW'(MAX_WAIT) && bus.dbg_req) dbgGnt = 1'b1;
            else if (bus.core_req)                      coreGnt = 1'b1;
            else if (bus.dbg_req)                       dbgGnt = 1'b1;
         end
         StLock:    dbgGnt  = bus.dbg_req;
         StRelease: coreGnt = bus.core_req;
         default: ;
      endcase
      // No access may reach the RAM while reset is held.
      if (!clear) begin
         coreGnt = 1'b0;
         dbgGnt  = 1'b0;
      end
   end

   always_comb begin
      bus.mem_addr  = {AW{1'b0}};
      bus.mem_din   = {DW{1'b0}};
      bus.mem_func3 = 3'd0;
      bus.mem_wren  = 1'b0;
      if (coreGnt) begin
         bus.mem_addr  = bus.core_addr;
         bus.mem_din   = bus.core_wdata;
         bus.mem_func3 = bus.core_func3;
         bus.mem_wren  = bus.core_we;
      end else if (dbgGnt) begin
         bus.mem_addr  = bus.dbg_addr;
         bus.mem_din   = bus.dbg_wdata;
         bus.mem_func3 = bus.dbg_func3;
         bus.mem_wren  = bus.dbg_we;
      end
   end

   assign bus.core_gnt    = coreGnt;
   assign bus.dbg_gnt     = dbgGnt;
   assign bus.core_stall  = bus.core_req & ~coreGnt;
   assign bus.core_rvalid = rdPending & ~rdOwnerDbg;
   assign bus.dbg_rvalid  = rdPending & rdOwnerDbg;
   assign bus.core_rdata  = bus.core_rvalid ? bus.mem_dout : {DW{1'b0}};
   assign bus.dbg_rdata   = bus.dbg_rvalid ? bus.mem_dout : {DW{1'b0}};

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state      <= StCore;
         waitCnt    <= '0;
         lockCnt    <= '0;
         rdPending  <= 1'b0;
         rdOwnerDbg <= 1'b0;
      end else begin
         rdPending  <= (coreGnt & ~bus.core_we) | (dbgGnt & ~bus.dbg_we);
         rdOwnerDbg <= dbgGnt;

         if (dbgGnt || !bus.dbg_req)      waitCnt <= '0;
         else if (waitCnt != WW'(MAX_WAIT)) waitCnt <= waitCnt + 1'b1;

         unique case (state)
            StCore: begin
               lockCnt <= '0;
               if (dbgGnt && bus.dbg_lock) state <= StLock;
            end
            StLock: begin
               lockCnt <= lockCnt + 1'b1;
               if (!bus.dbg_lock || lockCnt == LW'(LOCK_MAX - 1)) state <= StRelease;
            end
            StRelease: begin
               lockCnt <= '0;
               state   <= StCore;
            end
            default: begin
               lockCnt <= '0;
               state   <= StCore;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboarded bench for dmem_arbiter: per-cycle grant/mux checks against hand-derived
// expectations, read data queued at grant time and compared on return.
module tb_dmem_arbiter;
   logic clock = 1'b0;
   logic clear = 1'b1;

   dmem_arbiter_if #(.AW(8), .DW(32)) bus ();

   dmem_arbiter #(.AW(8), .DW(32), .MAX_WAIT(3), .LOCK_MAX(8)) dut (
      .clock (clock),
      .clear (clear),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   logic [31:0] ram    [256];
   logic [31:0] shadow [256];

   always @(posedge clock) begin
      if (bus.mem_wren) ram[bus.mem_addr] <= bus.mem_din;
      bus.mem_dout <= ram[bus.mem_addr];
   end

   int unsigned nVec = 0;
   int unsigned nErr = 0;
   logic [31:0] coreQ[$];
   logic [31:0] dbgQ[$];
   logic        expRvCore = 1'b0;
   logic        expRvDbg  = 1'b0;

   task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nVec++;
      if (got !== exp) begin
         nErr++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic checkReturn();
      logic [31:0] e;
      checkEq("core_rvalid", 64'(bus.core_rvalid), 64'(expRvCore));
      checkEq("dbg_rvalid", 64'(bus.dbg_rvalid), 64'(expRvDbg));
      e = 32'd0;
      if (expRvCore && coreQ.size() > 0) e = coreQ.pop_front();
      checkEq("core_rdata", 64'(bus.core_rdata), 64'(e));
      e = 32'd0;
      if (expRvDbg && dbgQ.size() > 0) e = dbgQ.pop_front();
      checkEq("dbg_rdata", 64'(bus.dbg_rdata), 64'(e));
   endtask

   // One clock cycle: drive requests, check grants/mux, schedule expected read returns.
   task automatic cyc(input logic cr, input logic cwe, input logic [7:0] ca,
                      input logic [31:0] cd, input logic dr, input logic dwe, input logic dl,
                      input logic [7:0] da, input logic [31:0] dd,
                      input logic eCg, input logic eDg);
      logic [7:0]  eAddr;
      logic [31:0] eDin;
      logic [2:0]  eF3;
      logic        eWe;
      @(posedge clock);
      #1;
      bus.core_req = cr; bus.core_we = cwe; bus.core_addr = ca; bus.core_wdata = cd;
      bus.core_func3 = cr ? 3'd2 : 3'd0;
      bus.dbg_req = dr; bus.dbg_we = dwe; bus.dbg_lock = dl; bus.dbg_addr = da;
      bus.dbg_wdata = dd; bus.dbg_func3 = dr ? 3'd5 : 3'd0;
      #1;
      checkReturn();
      checkEq("core_gnt", 64'(bus.core_gnt), 64'(eCg));
      checkEq("dbg_gnt", 64'(bus.dbg_gnt), 64'(eDg));
      checkEq("core_stall", 64'(bus.core_stall), 64'(cr & ~eCg));
      eAddr = eCg ? ca : (eDg ? da : 8'd0);
      eDin  = eCg ? cd : (eDg ? dd : 32'd0);
      eF3   = eCg ? 3'd2 : (eDg ? 3'd5 : 3'd0);
      eWe   = eCg ? cwe : (eDg ? dwe : 1'b0);
      checkEq("mem_addr", 64'(bus.mem_addr), 64'(eAddr));
      checkEq("mem_din", 64'(bus.mem_din), 64'(eDin));
      checkEq("mem_func3", 64'(bus.mem_func3), 64'(eF3));
      checkEq("mem_wren", 64'(bus.mem_wren), 64'(eWe));
      expRvCore = eCg & ~cwe;
      expRvDbg  = eDg & ~dwe;
      if (expRvCore) coreQ.push_back(shadow[ca]);
      if (expRvDbg)  dbgQ.push_back(shadow[da]);
      if (eCg && cwe) shadow[ca] = cd;
      if (eDg && dwe) shadow[da] = dd;
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         ram[i] = 32'h0;
         shadow[i] = 32'h0;
      end
      ram[8'h20] = 32'h12345678; shadow[8'h20] = 32'h12345678;
      ram[8'h21] = 32'hCAFEF00D; shadow[8'h21] = 32'hCAFEF00D;
      bus.core_req = 1'b0; bus.core_we = 1'b0; bus.core_addr = '0; bus.core_wdata = '0;
      bus.core_func3 = '0; bus.dbg_req = 1'b0; bus.dbg_we = 1'b0; bus.dbg_lock = 1'b0;
      bus.dbg_addr = '0; bus.dbg_wdata = '0; bus.dbg_func3 = '0;

      // Reset state
      #2 clear = 1'b0;
      #1;
      checkEq("rst_core_gnt", 64'(bus.core_gnt), 64'd0);
      checkEq("rst_dbg_gnt", 64'(bus.dbg_gnt), 64'd0);
      checkEq("rst_core_rvalid", 64'(bus.core_rvalid), 64'd0);
      checkEq("rst_dbg_rvalid", 64'(bus.dbg_rvalid), 64'd0);
      checkEq("rst_core_rdata", 64'(bus.core_rdata), 64'd0);
      checkEq("rst_dbg_rdata", 64'(bus.dbg_rdata), 64'd0);
      checkEq("rst_mem_wren", 64'(bus.mem_wren), 64'd0);
      #19 clear = 1'b1;

      // Core-only write then read back
      cyc(1'b1, 1'b1, 8'h10, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 8'h10, 32'h0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0);
      idle();

      // Contention: dbg forced in every 4th cycle
      for (int i = 0; i < 12; i++)
         cyc(1'b1, 1'b0, 8'h10, 32'h0, 1'b1, 1'b0, 1'b0, 8'h20, 32'h0,
             (i % 4) != 3, (i % 4) == 3);
      idle();

      // Full lock window: entry + 8 lock cycles, then release slot for the core
      cyc(1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b1, 1'b1, 8'h40, 32'hA0, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++)
         cyc(1'b1, 1'b0, 8'h10, 32'h0, 1'b1, 1'b1, 1'b1, 8'(8'h41 + i), 32'(32'hA1 + i),
             1'b0, 1'b1);
      cyc(1'b1, 1'b0, 8'h10, 32'h0, 1'b1, 1'b1, 1'b1, 8'h49, 32'hA9, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 8'h44, 32'h0, 1'b1, 1'b1, 1'b1, 8'h49, 32'hA9, 1'b1, 1'b0);
      idle();

      // Early unlock, including a lock-held idle cycle
      cyc(1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b1, 1'b1, 8'h50, 32'h11, 1'b0, 1'b1);
      cyc(1'b1, 1'b0, 8'h50, 32'h0, 1'b0, 1'b0, 1'b1, 8'h00, 32'h0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 8'h50, 32'h0, 1'b1, 1'b1, 1'b1, 8'h51, 32'h22, 1'b0, 1'b1);
      cyc(1'b1, 1'b0, 8'h50, 32'h0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 8'h50, 32'h0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 8'h51, 32'h0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0);
      idle();

      // Read routing: dbg read then core read back-to-back
      cyc(1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0, 8'h20, 32'h0, 1'b0, 1'b1);
      cyc(1'b1, 1'b0, 8'h21, 32'h0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0);
      idle();

      // Asynchronous reset mid-lock with a read pending
      cyc(1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b1, 8'h20, 32'h0, 1'b0, 1'b1);
      cyc(1'b1, 1'b0, 8'h21, 32'h0, 1'b1, 1'b0, 1'b1, 8'h21, 32'h0, 1'b0, 1'b1);
      @(posedge clock);
      #1;
      checkReturn();
      clear = 1'b0;
      #1;
      checkEq("arst_core_gnt", 64'(bus.core_gnt), 64'd0);
      checkEq("arst_dbg_gnt", 64'(bus.dbg_gnt), 64'd0);
      checkEq("arst_core_rvalid", 64'(bus.core_rvalid), 64'd0);
      checkEq("arst_dbg_rvalid", 64'(bus.dbg_rvalid), 64'd0);
      checkEq("arst_mem_wren", 64'(bus.mem_wren), 64'd0);
      expRvCore = 1'b0;
      expRvDbg  = 1'b0;
      bus.core_req = 1'b0; bus.dbg_req = 1'b0; bus.dbg_lock = 1'b0;
      @(negedge clock);
      clear = 1'b1;
      cyc(1'b1, 1'b0, 8'h10, 32'h0, 1'b1, 1'b0, 1'b1, 8'h20, 32'h0, 1'b1, 1'b0);
      idle();

      checkEq("sb_drained", 64'(coreQ.size() + dbgQ.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end
endmodule
